// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the register-index type.
// Holds register width, index width, register count and the hard-zero index.
// Imported by the register file, its decoder and the destination mux.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Register index as produced by the rt/rd destination mux.
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // r0 is hard-wired: reads return 0, writes and issues to it are dropped.
  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/reg_dec.sv
// One-hot register-index decoder with enable; bit 0 is always low.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no state.
//
// Ports:
//   i_en      decode enable; when low the output is all zeros
//   i_addr    register index to decode
//   o_onehot  one-hot select, bit i set when i_en && i_addr == i && i != 0
module reg_dec #(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
    // r0 can never be written or marked pending, so its select is killed here
    // once instead of being special-cased by every consumer.
    o_onehot[0] = 1'b0;
  end

endmodule : reg_dec

// File: rtl/reg_file_sb.sv
// 32x32 MIPS register file with a pending-write scoreboard for RAW stalls.
// Latency: reads and busy flags 0 cycles (writeback bypassed); writes and busy updates 1 cycle.
// Backpressure: none; decode stalls itself on rs_busy/rt_busy.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   rs_addr/rt_addr     read indices from decode
//   rs_data/rt_data     combinational read data, r0 reads 0, same-cycle writeback bypassed
//   rs_busy/rt_busy     read register has an outstanding writer not retiring this cycle
//   iss_valid/iss_dst   instruction with a destination issues; marks iss_dst pending
//   wb_en/wb_addr/wb_data  writeback strobe; stores data and clears the pending bit
//   busy_vec            registered scoreboard, bit i = register i pending
//   pend_cnt            registered popcount of busy_vec
module reg_file_sb #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  output logic                   rs_busy,
  output logic                   rt_busy,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_dst,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Storage and scoreboard state.
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_cnt;

  // Decoded issue and writeback selects (bit 0 already forced low).
  logic [NUM_REGS-1:0] w_iss_vec;
  logic [NUM_REGS-1:0] w_wb_vec;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;

  // Bypass / mask terms for the two read ports.
  logic                w_rs_wb_hit;
  logic                w_rt_wb_hit;

  reg_dec #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_iss_dec (
    .i_en     (iss_valid),
    .i_addr   (iss_dst),
    .o_onehot (w_iss_vec)
  );

  reg_dec #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wb_dec (
    .i_en     (wb_en),
    .i_addr   (wb_addr),
    .o_onehot (w_wb_vec)
  );

  // Set has priority over clear: an issue in the same cycle as a writeback to
  // that register is a newer writer, so the register must stay pending.
  always_comb begin
    w_busy_nxt    = w_iss_vec | (r_busy & ~w_wb_vec);
    w_busy_nxt[0] = 1'b0;
  end

  // The count is computed from the next-state vector so pend_cnt and busy_vec
  // always move together on the same edge.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // r_regs[0] is only ever loaded with zero; reads of r0 bypass it anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wb_vec[i]) begin
          r_regs[i] <= wb_data;
        end
      end
    end
  end

  // A writeback hit lets decode consume the result in the writeback cycle:
  // data comes from the bypass and the pending flag is masked.
  assign w_rs_wb_hit = wb_en && (wb_addr == rs_addr);
  assign w_rt_wb_hit = wb_en && (wb_addr == rt_addr);

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == mips_pkg::REG_ZERO) begin
      rs_data = '0;
    end else if (w_rs_wb_hit) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == mips_pkg::REG_ZERO) begin
      rt_data = '0;
    end else if (w_rt_wb_hit) begin
      rt_data = wb_data;
    end
  end

  // busy bit 0 is never set, so r0 never stalls without a special case here.
  assign rs_busy  = r_busy[rs_addr] && !w_rs_wb_hit;
  assign rt_busy  = r_busy[rt_addr] && !w_rt_wb_hit;

  assign busy_vec = r_busy;
  assign pend_cnt = r_cnt;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations queued when stimulus is driven,
// popped and compared at the mid-cycle sample point.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        rs_busy, rt_busy;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;
  logic [5:0]  pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Output selectors for queued expectations.
  localparam int S_RS_DATA = 0;
  localparam int S_RT_DATA = 1;
  localparam int S_RS_BUSY = 2;
  localparam int S_RT_BUSY = 3;
  localparam int S_BUSYVEC = 4;
  localparam int S_PENDCNT = 5;

  string       q_tag [$];
  int          q_sel [$];
  logic [31:0] q_exp [$];

  reg_file_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy_vec  (busy_vec),
    .pend_cnt  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RS_DATA: return rs_data;
      S_RT_DATA: return rt_data;
      S_RS_BUSY: return {31'd0, rs_busy};
      S_RT_BUSY: return {31'd0, rt_busy};
      S_BUSYVEC: return busy_vec;
      S_PENDCNT: return {26'd0, pend_cnt};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  task automatic check_all();
    string       tag;
    int          sel;
    logic [31:0] exp_v;
    logic [31:0] obs;
    while (q_exp.size() > 0) begin
      tag   = q_tag.pop_front();
      sel   = q_sel.pop_front();
      exp_v = q_exp.pop_front();
      obs   = observe(sel);
      n_tests++;
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle, well clear of both edges.
  task automatic sample();
    #2;
    check_all();
  endtask

  initial begin
    logic [63:0] ones;
    rst_n = 1'b0; rs_addr = '0; rt_addr = '0;
    iss_valid = 1'b0; iss_dst = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Post-reset state.
    rs_addr = 5'd5; rt_addr = 5'd0;
    expect_val("rst_rs_data", S_RS_DATA, 32'h0);
    expect_val("rst_rt_data", S_RT_DATA, 32'h0);
    expect_val("rst_busy_vec", S_BUSYVEC, 32'h0);
    expect_val("rst_pend_cnt", S_PENDCNT, 32'd0);
    expect_val("rst_rs_busy", S_RS_BUSY, 32'd0);
    sample();

    // Issue dst=8.
    iss_valid = 1'b1; iss_dst = 5'd8;
    tick();
    iss_valid = 1'b0; rs_addr = 5'd8;
    expect_val("iss8_rs_busy", S_RS_BUSY, 32'd1);
    expect_val("iss8_busy_vec", S_BUSYVEC, 32'h0000_0100);
    expect_val("iss8_pend_cnt", S_PENDCNT, 32'd1);
    sample();

    // Writeback 8 <- 0xAB: bypassed and unmasked in the same cycle.
    tick();
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_00AB;
    expect_val("wb8_rs_data_bypass", S_RS_DATA, 32'h0000_00AB);
    expect_val("wb8_rs_busy_masked", S_RS_BUSY, 32'd0);
    expect_val("wb8_busy_vec_still", S_BUSYVEC, 32'h0000_0100);
    sample();
    tick();
    wb_en = 1'b0;
    expect_val("wb8_busy_vec_clr", S_BUSYVEC, 32'h0);
    expect_val("wb8_pend_cnt_clr", S_PENDCNT, 32'd0);
    expect_val("wb8_rs_data_stored", S_RS_DATA, 32'h0000_00AB);
    sample();

    // Same-cycle issue and writeback to 12: set wins, data still written.
    iss_valid = 1'b1; iss_dst = 5'd12;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_1234;
    tick();
    iss_valid = 1'b0; wb_en = 1'b0; rs_addr = 5'd12; rt_addr = 5'd12;
    expect_val("same12_busy_vec", S_BUSYVEC, 32'h0000_1000);
    expect_val("same12_pend_cnt", S_PENDCNT, 32'd1);
    expect_val("same12_rs_data", S_RS_DATA, 32'h0000_1234);
    expect_val("same12_rt_data", S_RT_DATA, 32'h0000_1234);
    expect_val("same12_rt_busy", S_RT_BUSY, 32'd1);
    sample();

    // Writes and issues to r0 are dropped, no bypass for r0.
    tick();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_dst = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    expect_val("r0_rs_data_nobypass", S_RS_DATA, 32'h0);
    expect_val("r0_rs_busy", S_RS_BUSY, 32'd0);
    sample();
    tick();
    wb_en = 1'b0; iss_valid = 1'b0;
    expect_val("r0_rs_data", S_RS_DATA, 32'h0);
    expect_val("r0_busy_vec", S_BUSYVEC, 32'h0000_1000);
    expect_val("r0_pend_cnt", S_PENDCNT, 32'd1);
    sample();

    // Writeback to a non-busy register: rt bypass, then stored, busy unchanged.
    tick();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0055;
    rt_addr = 5'd3;
    expect_val("wb3_rt_data_bypass", S_RT_DATA, 32'h0000_0055);
    sample();
    tick();
    wb_en = 1'b0;
    expect_val("wb3_rt_data_stored", S_RT_DATA, 32'h0000_0055);
    expect_val("wb3_busy_vec", S_BUSYVEC, 32'h0000_1000);
    sample();

    // Retire 12 with rt reading it: rt_busy masked in the writeback cycle.
    tick();
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hCAFE_0012;
    rt_addr = 5'd12;
    expect_val("wb12_rt_busy_masked", S_RT_BUSY, 32'd0);
    expect_val("wb12_rt_data_bypass", S_RT_DATA, 32'hCAFE_0012);
    sample();
    tick();
    wb_en = 1'b0;
    expect_val("wb12_busy_vec", S_BUSYVEC, 32'h0);
    expect_val("wb12_pend_cnt", S_PENDCNT, 32'd0);
    sample();

    // Issue to 1..31 on consecutive cycles.
    iss_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      iss_dst = 5'(i);
      tick();
      ones = (64'd1 << (i + 1)) - 64'd1;
      expect_val($sformatf("fill_pend_%0d", i), S_PENDCNT, 32'(i));
      expect_val($sformatf("fill_vec_%0d", i), S_BUSYVEC, ones[31:0] & 32'hFFFF_FFFE);
      sample();
    end
    iss_valid = 1'b0;

    // Reset asserted mid-sequence, between clock edges.
    rs_addr = 5'd8;
    rst_n = 1'b0;
    #1;
    expect_val("arst_busy_vec", S_BUSYVEC, 32'h0);
    expect_val("arst_pend_cnt", S_PENDCNT, 32'd0);
    expect_val("arst_rs_busy", S_RS_BUSY, 32'd0);
    expect_val("arst_rs_data", S_RS_DATA, 32'h0);
    check_all();

    // Issue while reset is held is ignored.
    iss_valid = 1'b1; iss_dst = 5'd20;
    tick();
    expect_val("arst_hold_busy_vec", S_BUSYVEC, 32'h0);
    sample();

    // First edge after release is a normal cycle.
    tick();
    rst_n = 1'b1; iss_dst = 5'd5;
    tick();
    iss_valid = 1'b0; rs_addr = 5'd5;
    expect_val("post_rst_busy_vec", S_BUSYVEC, 32'h0000_0020);
    expect_val("post_rst_pend_cnt", S_PENDCNT, 32'd1);
    expect_val("post_rst_rs_busy", S_RS_BUSY, 32'd1);
    rt_addr = 5'd3;
    expect_val("post_rst_rt_data", S_RT_DATA, 32'h0);
    sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file_sb
